// File: rtl/mux_pkg.sv
// Shared definitions for the selectable-source mux pipeline.
// Holds the mode encoding used on the mode input of mux_sel_pipe
// and rr_grant.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;  // grant the channel named by sel
  localparam logic MODE_RR    = 1'b1;  // round-robin search after ptr

endpackage

// File: rtl/rr_grant.sv
// Grant generator for mux_sel_pipe.
// Produces a one-hot (or all-zero) grant over N requesters.
//   req   : per-channel request (in_valid)
//   ptr   : index of the most recently granted channel
//   mode  : MODE_FIXED or MODE_RR
//   sel   : channel select used in fixed mode (values >= N grant nothing)
//   grant : one-hot grant, zero when nothing is eligible
module rr_grant
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [SW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (mode == MODE_FIXED) begin
      // Comparing against every legal index means an out-of-range sel
      // simply matches nothing.
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && req[i]) grant[i] = 1'b1;
      end
    end else begin
      // Search starts one past the last winner and wraps modulo N.
      for (int k = 1; k <= N; k++) begin
        idx = SW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-to-1 selectable mux with a single registered output stage.
// A channel is chosen either by sel (fixed mode) or round-robin, and its
// word is captured into the output register with one cycle of latency.
// The stage reloads whenever it is empty or being drained, so it sustains
// one word per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   in_data   : N packed channels, channel i at [i*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (forced low during reset)
//   sel, mode : channel select and arbitration mode
//   out_data  : registered selected word
//   out_src   : registered source index of out_data
//   out_valid : output register holds a word
//   out_ready : downstream accepts the word
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic [SW-1:0] sel,
  input  logic          mode,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_src,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [N-1:0]  grant;
  logic          load_en;
  logic          take_p0;
  logic [W-1:0]  data_p0;
  logic [SW-1:0] src_p0;
  logic [W-1:0]  data_p1;
  logic [SW-1:0] src_p1;
  logic          vld_p1;
  logic [SW-1:0] ptr;

  // ---- stage p0: arbitration and selection (combinational) ----
  rr_grant #(.N(N), .SW(SW)) u_grant (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (mode),
    .sel   (sel),
    .grant (grant)
  );

  assign load_en  = !vld_p1 || out_ready;
  // rst gating keeps ready low while the async reset is held, even though
  // the empty output stage would otherwise look loadable.
  assign in_ready = {N{load_en && !rst}} & grant;
  assign take_p0  = load_en && (|grant);

  always_comb begin
    data_p0 = '0;
    src_p0  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        data_p0 = in_data[i*W +: W];
        src_p0  = SW'(i);
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr     <= SW'(N - 1);
    end else if (load_en) begin
      vld_p1 <= take_p0;
      // Data and source only move on a real transfer; a bubble keeps them.
      if (take_p0) begin
        data_p1 <= data_p0;
        src_p1  <= src_p0;
        ptr     <= src_p0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_src   = src_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_sel_pipe.sv
module tb_mux_sel_pipe;

  localparam int NCH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic [2:0]  sel6;
  logic        mode6;
  logic [7:0]  out_data6;
  logic [2:0]  out_src6;
  logic        out_valid6;
  logic        out_ready6;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_src;
  int         m_ptr;

  mux_sel_pipe #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_sel_pipe #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .sel(sel6), .mode(mode6), .out_data(out_data6),
    .out_src(out_src6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_grant();
    if (mode == 1'b0)
      return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    if (rst) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    g = model_grant();
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 2'd0;
    m_ptr   = NCH - 1;
  endtask

  task automatic model_edge();
    int g;
    if (rst) begin
      model_reset();
    end else if (!m_valid || out_ready) begin
      g = model_grant();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*8 +: 8];
        m_src   = 2'(g);
        m_ptr   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = $urandom();
    in_valid6 = '0; in_data6 = '0; sel6 = '0; mode6 = 1'b0; out_ready6 = 1'b1;
    model_reset();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++;
    if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got %0d want 0", out_src); end
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_rr got %b want 0001", in_ready); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = $urandom();
    in_data[23:16] = 8'hA5;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
      errors++;
      $display("FAIL fixed_out got v=%b d=%h s=%0d want v=1 d=a5 s=2", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_rr_seq();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(exp_src[i]) || out_data !== m_data) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, out_valid, out_src, out_data, exp_src[i], m_data);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    logic [1:0] held_src;
    held = m_data;
    held_src = m_src;
    out_ready = 1'b0; in_valid = 4'hF; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom();
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || out_src !== held_src) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, out_valid, out_data, out_src, held, held_src);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_fixed_invalid();
    logic [7:0] held;
    held = m_data;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b1;
    in_data = $urandom();
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL noval_ready got %b want 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== held) begin
      errors++;
      $display("FAIL noval_drain got v=%b d=%h want v=0 d=%h", out_valid, out_data, held);
    end
    // six-channel instance: top index and out-of-range select
    mode6 = 1'b0; sel6 = 3'd5; in_valid6 = 6'b100000; out_ready6 = 1'b1;
    in_data6 = {8'h5C, 40'h0};
    #1;
    checks++;
    if (in_ready6 !== 6'b100000) begin errors++; $display("FAIL n6_ready got %b want 100000", in_ready6); end
    tick();
    checks++;
    if (out_valid6 !== 1'b1 || out_data6 !== 8'h5C || out_src6 !== 3'd5) begin
      errors++;
      $display("FAIL n6_out got v=%b d=%h s=%0d want v=1 d=5c s=5", out_valid6, out_data6, out_src6);
    end
    sel6 = 3'd6; in_valid6 = 6'b111111;
    #1;
    checks++;
    if (in_ready6 !== 6'b000000) begin errors++; $display("FAIL n6_oor_ready got %b want 000000", in_ready6); end
    tick();
    checks++;
    if (out_valid6 !== 1'b0 || out_data6 !== 8'h5C) begin
      errors++;
      $display("FAIL n6_oor_out got v=%b d=%h want v=0 d=5c", out_valid6, out_data6);
    end
    in_valid6 = '0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_rdy[3] = '{4'b0001, 4'b1000, 4'b0001};
    int         exp_src[3] = '{0, 3, 0};
    do_reset();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b1;
    in_data = $urandom();
    tick();
    mode = 1'b1; in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom();
      #1;
      checks++;
      if (in_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL wrap_ready[%0d] got %b want %b", i, in_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(exp_src[i])) begin
        errors++;
        $display("FAIL wrap_src[%0d] got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_src, exp_src[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    in_data = $urandom();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst got v=%b r=%b want v=0 r=0000", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_rst_hold got v=%b r=%b d=%h want v=0 r=0000 d=00", out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL post_rst_ready got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL post_rst_src got v=%b s=%0d want v=1 s=0", out_valid, out_src);
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom());
      in_data   = $urandom();
      mode      = 1'($urandom());
      sel       = 2'($urandom());
      out_ready = ($urandom_range(3) != 0);
      #1;
      er = model_ready();
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, er);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src) begin
        errors++;
        $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 i, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_seq();
    test_stall();
    test_fixed_invalid();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 Parameter: N, default 4, number of input channels (N >= 2).
REQ-002 Parameter: W, default 8, data width per channel (W >= 1).
REQ-003 Parameter: SW, default $clog2(N), select/index width.
REQ-004 Port: clk  in  1  sole clock; all state on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: in_data  in  N*W  channel i occupies bits [i*W +: W].
REQ-007 Port: in_valid  in  N  per-channel valid.
REQ-008 Port: in_ready  out  N  per-channel ready; combinational from grant and output-stage state.
REQ-009 Port: sel  in  SW  channel select, used in fixed mode.
REQ-010 Port: mode  in  1  0 = fixed select, 1 = round-robin.
REQ-011 Port: out_data  out  W  registered selected data.
REQ-012 Port: out_src  out  SW  registered index of the source channel of out_data.
REQ-013 Port: out_valid  out  1  output register holds a valid word.
REQ-014 Port: out_ready  in  1  downstream accepts the word when high with out_valid.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready); single registered stage, full throughput.
REQ-016 Fixed mode: grant = one-hot(sel) when sel < N and in_valid[sel]; sel >= N SHALL grant nothing.
REQ-017 Round-robin mode: grant SHALL go to the first valid channel searching ptr+1, ptr+2, ... wrapping modulo N.
REQ-018 At most one grant bit SHALL be set per cycle; in_ready[i] = load_en && grant[i].
REQ-019 An input transfer SHALL occur when in_valid[i] && in_ready[i]; out_data/out_src SHALL load that channel's data/index on the same edge, and out_valid SHALL go to 1.
REQ-020 Latency in-accept to out_valid SHALL be exactly 1 cycle.
REQ-021 If load_en and no grant, out_valid SHALL go to 0 at the edge; out_data/out_src SHALL hold.
REQ-022 If out_valid && !out_ready, out_data, out_src, out_valid SHALL hold and all in_ready SHALL be 0.
REQ-023 ptr SHALL update to the granted index on every input transfer, in either mode; otherwise hold.
REQ-024 Simultaneous output drain and input accept SHALL keep out_valid = 1 with no bubble.
REQ-025 mode and sel SHALL be sampled combinationally each cycle; changes affect only the current cycle's grant, never a held output word.
REQ-026 Wrap-around: with ptr = N-1 the search SHALL start at channel 0.

Reset
REQ-027 On rst: out_valid = 0, out_data = 0, out_src = 0, ptr = N-1 (first round-robin priority to channel 0).
REQ-028 While rst is high, in_ready SHALL be all 0; a reset mid-transfer discards the held word.

Structure
REQ-029 Shared package mux_pkg SHALL hold the mode encoding constants (MODE_FIXED = 0, MODE_RR = 1).
REQ-030 Grant logic SHALL be a sub-module rr_grant (inputs req, ptr, mode, sel; output one-hot grant); the output register stays in mux_sel_pipe.

Verification
REQ-031 N=4, W=8, mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_src=2.
REQ-032 mode=1, in_valid=4'b1111 held, out_ready=1, after reset -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 out_valid=1 with out_ready=0 for 3 cycles, in_valid=4'b1111 -> out_data stable, in_ready=4'b0000 throughout.
REQ-034 mode=0, sel=2, in_valid[2]=0 -> in_ready=0, out_valid falls after one drain cycle; sel=5 with N=6 boundary variant selects ch5.
REQ-035 mode=1, ptr=3, in_valid=4'b1001 -> grant ch0 (wrap), then ch3, then ch0.
REQ-036 rst asserted asynchronously mid-stream with out_valid=1 -> out_valid=0 and in_ready=0 immediately; after release first round-robin grant is ch0.
